// File: rtl/dot_product_if.sv
// Bus between the dot-product sequencer, its operand memory and the
// consumer of the result. The sequencer connects through the slave
// modport; the operand memory and the consumer connect through master.
//
// Handshake: start is a level request, taken on any rising edge where the
// sequencer is idle; len is captured on that same edge. mem_rd is a read
// strobe with no back-pressure, and mem_a/mem_b must carry the addressed
// pair in the cycle after the strobe. done is high for one cycle, and
// result is valid from that cycle until the next done.
interface dot_product_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 32
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_b;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;

  modport slave (
    input  start, len, mem_a, mem_b,
    output mem_rd, mem_addr, busy, done, result
  );

  modport master (
    output start, len, mem_a, mem_b,
    input  mem_rd, mem_addr, busy, done, result
  );
endinterface

// File: rtl/dot_product_ctrl.sv
// Sequencer for an unsigned dot product. It streams len operand pairs out
// of a synchronous-read memory into a product register followed by an
// accumulator. It reports the sum with a one-cycle done and holds the
// result until the next run completes.
module dot_product_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  dot_product_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     len_sat;
  logic                start_ok;
  logic                last_rd;
  logic                rd_v;    // mem_a/mem_b carry a requested pair this cycle
  logic                prod_v;  // prod holds a product not yet accumulated
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;

  assign len_sat   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
  assign start_ok  = (state == S_IDLE) && bus.start;
  assign last_rd   = ((cnt + ONE) == len_q);
  // Accumulator input for this edge. result loads this value directly so
  // that the last product lands in result on the edge that enters DONE.
  assign acc_sum   = acc + (prod_v ? ACC_W'(prod) : {ACC_W{1'b0}});
  assign state_dbg = state;

  // State register; reset abandons any run in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (len_sat == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = cnt[ADDR_W-1:0];
        bus.busy     = 1'b1;
        if (last_rd) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        // Once no operands are left on the memory bus, the product stage
        // holds the final term and is added on the way into DONE.
        if (!rd_v) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read counter, valid pipeline, product register and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      cnt    <= '0;
      rd_v   <= 1'b0;
      prod_v <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else if (start_ok) begin
      len_q  <= len_sat;
      cnt    <= '0;
      rd_v   <= 1'b0;
      prod_v <= 1'b0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      rd_v   <= bus.mem_rd;
      prod_v <= rd_v;
      acc    <= acc_sum;
      if (rd_v)             prod <= bus.mem_a * bus.mem_b;
      if (state == S_FETCH) cnt  <= cnt + ONE;
    end
  end

  // Result register, loaded only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       bus.result <= '0;
    else if (start_ok && (len_sat == '0))          bus.result <= '0;
    else if ((state == S_DRAIN) && (state_nxt == S_DONE)) bus.result <= acc_sum;
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl. A 32-bit instance covers the main scenarios
// and a 16-bit instance covers accumulator wrap. Expected sums come from
// plain arithmetic over the operand arrays. Expected timing comes from the
// run length: done occurs len+3 samples after start, and busy is high for
// len+2 cycles.
module tb_dot_product_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_if #(.DATA_W(8), .ADDR_W(6), .ACC_W(32)) bus0 ();
  dot_product_if #(.DATA_W(8), .ADDR_W(6), .ACC_W(16)) bus1 ();
  logic [1:0] state_dbg0, state_dbg1;

  dot_product_ctrl #(.DATA_W(8), .ADDR_W(6), .ACC_W(32)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(state_dbg0));
  dot_product_ctrl #(.DATA_W(8), .ADDR_W(6), .ACC_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(state_dbg1));

  int ma0[64], mb0[64], ma1[64], mb1[64];

  // Synchronous-read operand memories.
  always @(posedge clk) begin
    if (bus0.mem_rd) begin
      bus0.mem_a <= 8'(ma0[bus0.mem_addr]);
      bus0.mem_b <= 8'(mb0[bus0.mem_addr]);
    end
    if (bus1.mem_rd) begin
      bus1.mem_a <= 8'(ma1[bus1.mem_addr]);
      bus1.mem_b <= 8'(mb1[bus1.mem_addr]);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Observations from the most recent do_run.
  int          r_done_t, r_done_cnt, r_busy_cnt, r_rd_cnt, r_addr_bad, r_early;
  logic [31:0] r_res;

  function automatic logic [31:0] ref_dot(input int n);
    longint s = 0;
    int m = (n > 64) ? 64 : n;
    for (int i = 0; i < m; i++) s += longint'(ma0[i]) * longint'(mb0[i]);
    return s[31:0];
  endfunction

  // Start a run on dut0, optionally pulse start again at sample poke_t,
  // and observe the run until the sample after done (bounded).
  task automatic do_run(input int n, input int poke_t, input logic [31:0] prev_res);
    r_done_t = -1; r_done_cnt = 0; r_busy_cnt = 0; r_rd_cnt = 0;
    r_addr_bad = 0; r_early = 0; r_res = '0;
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.len   = 7'(n);
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (t == 1) bus0.start = 1'b0;
      if (t == poke_t) begin bus0.start = 1'b1; bus0.len = 7'd3; end
      else if (t == poke_t + 1) bus0.start = 1'b0;
      if (bus0.mem_rd) begin
        if (int'(bus0.mem_addr) != t - 1) r_addr_bad++;
        r_rd_cnt++;
      end
      if (bus0.busy) r_busy_cnt++;
      if (bus0.done) r_done_cnt++;
      if (bus0.done && r_done_t < 0) begin
        r_done_t = t;
        r_res    = bus0.result;
      end else if (r_done_t < 0 && bus0.result !== prev_res) r_early++;
      if (r_done_t >= 0 && t > r_done_t) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (bus0.mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd got %b want 0", bus0.mem_rd); end
    n_vec++; if (bus0.mem_addr !== 6'd0) begin n_err++; $display("FAIL reset_mem_addr got %0d want 0", bus0.mem_addr); end
    n_vec++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
    n_vec++; if (bus0.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus0.done); end
    n_vec++; if (bus0.result !== 32'd0) begin n_err++; $display("FAIL reset_result got %0d want 0", bus0.result); end
  endtask

  task automatic test_len4();
    for (int i = 0; i < 4; i++) begin ma0[i] = 2 * i + 1; mb0[i] = 2 * i + 2; end
    do_run(4, 0, 32'd0);
    n_vec++; if (r_res !== 32'd100) begin n_err++; $display("FAIL len4_result got %0d want 100", r_res); end
    n_vec++; if (r_done_t != 7) begin n_err++; $display("FAIL len4_done_time got %0d want 7", r_done_t); end
    n_vec++; if (r_done_cnt != 1) begin n_err++; $display("FAIL len4_done_pulses got %0d want 1", r_done_cnt); end
    n_vec++; if (r_busy_cnt != 6) begin n_err++; $display("FAIL len4_busy_cycles got %0d want 6", r_busy_cnt); end
    n_vec++; if (r_rd_cnt != 4 || r_addr_bad != 0) begin n_err++; $display("FAIL len4_reads got %0d reads %0d bad want 4 reads 0 bad", r_rd_cnt, r_addr_bad); end
  endtask

  task automatic test_len0();
    do_run(0, 0, 32'd100);
    n_vec++; if (r_done_t != 1) begin n_err++; $display("FAIL len0_done_time got %0d want 1", r_done_t); end
    n_vec++; if (r_res !== 32'd0) begin n_err++; $display("FAIL len0_result got %0d want 0", r_res); end
    n_vec++; if (r_rd_cnt != 0 || r_busy_cnt != 0) begin n_err++; $display("FAIL len0_activity got %0d reads %0d busy want 0 0", r_rd_cnt, r_busy_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 64; i++) begin ma0[i] = 255; mb0[i] = 255; end
    do_run(64, 0, 32'd0);
    n_vec++; if (r_res !== 32'd4161600) begin n_err++; $display("FAIL sat64_result got %0d want 4161600", r_res); end
    n_vec++; if (r_done_t != 67) begin n_err++; $display("FAIL sat64_done_time got %0d want 67", r_done_t); end
    do_run(100, 0, 32'd4161600);
    n_vec++; if (r_rd_cnt != 64 || r_addr_bad != 0) begin n_err++; $display("FAIL sat100_reads got %0d reads %0d bad want 64 reads 0 bad", r_rd_cnt, r_addr_bad); end
    n_vec++; if (r_res !== 32'd4161600) begin n_err++; $display("FAIL sat100_result got %0d want 4161600", r_res); end
  endtask

  task automatic test_random();
    logic [31:0] prev = 32'd4161600;
    for (int k = 0; k < 8; k++) begin
      int n  = $urandom_range(0, 127);
      int ne = (n > 64) ? 64 : n;
      logic [31:0] exp;
      for (int i = 0; i < 64; i++) begin ma0[i] = $urandom_range(0, 255); mb0[i] = $urandom_range(0, 255); end
      exp = (ne == 0) ? 32'd0 : ref_dot(n);
      do_run(n, 0, prev);
      n_vec++; if (r_res !== exp) begin n_err++; $display("FAIL rand%0d_result len %0d got %0d want %0d", k, n, r_res, exp); end
      n_vec++; if (r_done_t != ((ne == 0) ? 1 : ne + 3)) begin n_err++; $display("FAIL rand%0d_done_time len %0d got %0d want %0d", k, n, r_done_t, (ne == 0) ? 1 : ne + 3); end
      n_vec++; if (r_busy_cnt != ((ne == 0) ? 0 : ne + 2)) begin n_err++; $display("FAIL rand%0d_busy len %0d got %0d want %0d", k, n, r_busy_cnt, (ne == 0) ? 0 : ne + 2); end
      n_vec++; if (r_rd_cnt != ne || r_addr_bad != 0 || r_early != 0) begin n_err++; $display("FAIL rand%0d_reads len %0d got %0d reads %0d bad %0d early want %0d 0 0", k, n, r_rd_cnt, r_addr_bad, r_early, ne); end
      prev = exp;
    end
  endtask

  task automatic test_ignore_start();
    for (int i = 0; i < 4; i++) begin ma0[i] = 2 * i + 1; mb0[i] = 2 * i + 2; end
    do_run(4, 0, 32'd0);
    do_run(4, 3, r_res);
    n_vec++; if (r_res !== 32'd100 || r_done_cnt != 1 || r_done_t != 7) begin n_err++; $display("FAIL busy_start_ignored got %0d sum %0d pulses at %0d want 100 1 7", r_res, r_done_cnt, r_done_t); end
    ma0[0] = 9; mb0[0] = 9;
    do_run(1, 0, 32'd100);
    n_vec++; if (r_early != 0) begin n_err++; $display("FAIL result_hold got %0d early changes want 0", r_early); end
    n_vec++; if (r_res !== 32'd81) begin n_err++; $display("FAIL second_run_result got %0d want 81", r_res); end
  endtask

  task automatic test_reset_midrun();
    int dcnt = 0;
    for (int i = 0; i < 8; i++) begin ma0[i] = 7; mb0[i] = 7; end
    @(negedge clk);
    bus0.start = 1'b1; bus0.len = 7'd8;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus0.mem_rd !== 1'b0 || bus0.mem_addr !== 6'd0) begin n_err++; $display("FAIL midrst_mem got rd %b addr %0d want 0 0", bus0.mem_rd, bus0.mem_addr); end
    n_vec++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin n_err++; $display("FAIL midrst_status got busy %b done %b want 0 0", bus0.busy, bus0.done); end
    n_vec++; if (bus0.result !== 32'd0) begin n_err++; $display("FAIL midrst_result got %0d want 0", bus0.result); end
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (bus0.done) dcnt++; end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (bus0.done) dcnt++; end
    n_vec++; if (dcnt != 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", dcnt); end
    ma0[0] = 2; mb0[0] = 3; ma0[1] = 4; mb0[1] = 5;
    do_run(2, 0, 32'd0);
    n_vec++; if (r_res !== 32'd26 || r_done_t != 5) begin n_err++; $display("FAIL post_rst_run got %0d at %0d want 26 at 5", r_res, r_done_t); end
  endtask

  task automatic test_wrap();
    int dt = -1;
    logic [15:0] res = '0;
    ma1[0] = 255; mb1[0] = 255; ma1[1] = 255; mb1[1] = 255;
    @(negedge clk);
    bus1.start = 1'b1; bus1.len = 7'd2;
    for (int t = 1; t <= 50 && dt < 0; t++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.done) begin dt = t; res = bus1.result; end
    end
    n_vec++; if (res !== 16'd64514) begin n_err++; $display("FAIL wrap16_result got %0d want 64514", res); end
    n_vec++; if (dt != 5) begin n_err++; $display("FAIL wrap16_done_time got %0d want 5", dt); end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.len = '0;
    bus1.start = 1'b0; bus1.len = '0;
    for (int i = 0; i < 64; i++) begin ma0[i] = 0; mb0[i] = 0; ma1[i] = 0; mb1[i] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_len4();
    test_len0();
    test_saturate();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
# dot_product_ctrl

Sequencer for the multiply-accumulate datapath. On `start` it reads `len` operand pairs from a synchronous-read operand memory and feeds them through an internal two-stage MAC pipeline (product register, then accumulator). It raises a one-cycle `done` with the final sum and holds that sum until the next run. It sits between the operand buffer and any consumer needing unsigned dot products.

## Interface
- `DATA_W`, default 8: operand width (unsigned).
- `ADDR_W`, default 6: operand memory address width; at most 2^ADDR_W pairs per run.
- `ACC_W`, default 32: accumulator/result width; must be ≥ 2*DATA_W.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: level-sampled run request; accepted only in IDLE.
- `len`, in, ADDR_W+1: number of pairs, captured when `start` is accepted.
- `mem_rd`, out, 1: read strobe to operand memory.
- `mem_addr`, out, ADDR_W: read address.
- `mem_a`, in, DATA_W: operand A; valid the cycle after `mem_rd`.
- `mem_b`, in, DATA_W: operand B; valid the cycle after `mem_rd`.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, ACC_W: final sum of the last completed run.

## Operation
- States:
  - IDLE: `busy`=0.
  - FETCH: issue reads; `busy`=1.
  - DRAIN: empty the pipeline; `busy`=1.
  - DONE: `done`=1, `busy`=0.
- Transitions:
  - IDLE with `start`=1: capture `len` (values > 2^ADDR_W saturate to 2^ADDR_W), clear accumulator, product register and read counter. Go to FETCH if len > 0, else to DONE.
  - FETCH: `mem_rd`=1 and `mem_addr`=counter each cycle; counter increments. After the read with address len-1, go to DRAIN.
  - DRAIN: stay until the last product has been added to the accumulator, then go to DONE. On the DONE-entry edge, load `result` from the accumulator.
  - DONE: go to IDLE unconditionally; `start` is ignored in DONE.
- `start` is ignored in FETCH, DRAIN and DONE. A `start` still high in IDLE begins a new run, so back-to-back runs are spaced by one IDLE cycle.
- Datapath:
  - Product = `mem_a` * `mem_b`, unsigned, 2*DATA_W bits, registered.
  - Accumulate = acc + zero-extended product, modulo 2^ACC_W (silent wrap, no flag).
  - Product/accumulate stages are qualified by valid bits delayed from `mem_rd`. Nothing is added when the valid bit is low.
- `result` changes only on the DONE-entry edge. During a run it holds the previous run's sum; a len=0 run loads 0.
- `mem_addr` is 0 whenever `mem_rd`=0.
- Reset (asynchronous, any state, including mid-run):
  - State returns to IDLE immediately.
  - `mem_rd`, `mem_addr`, `busy`, `done`, `result`, accumulator, product and valid bits all go to 0.
  - In-flight data is discarded; the first `start` after reset release runs clean.

## Timing
- Edge E0 is the edge where `start` is accepted.
- Read k (k = 0..len-1) is issued in the cycle after edge E_k.
- Operand data for read k is present in the cycle after edge E_(k+1).
- Product k is registered at edge E_(k+2) and accumulated at edge E_(k+3).
- `result` is loaded and DONE is entered at edge E_(len+2). `done` is high for exactly the following cycle.
- `busy` rises after E0 and falls at E_(len+2).
- len=0: DONE is entered at E0; `done` is high for the cycle after E0; `result`=0.
- Total run latency from `start` acceptance to `done` is len+2 cycles; next `start` can be accepted at E_(len+4).

## Test plan
- len=4, pairs (1,2),(3,4),(5,6),(7,8):
  - `mem_addr` 0..3 in consecutive cycles.
  - `done` pulses once, at E6; `result`=100.
  - `busy` is high from E0 to E6.
- len=0 → `done` in the cycle after E0, `result`=0, `mem_rd` never asserted.
- len=64, all operands 255 → `result`=4161600, `done` at E66. With len=100, the run still reads only 64 pairs (saturation).
- ACC_W=16, len=2, operands 255 → `result`=64514 (130050 mod 65536, wrap).
- Run len=4 with sum 100, then a second `start` pulse while `busy` (ignored), then `start` in IDLE with len=1 and pair (9,9):
  - `result` holds 100 until the second run's `done`, then becomes 81.
- Assert `rst` asynchronously mid-FETCH of a len=8 run:
  - All outputs go to 0 immediately, with no `done`.
  - A subsequent len=2 run with pairs (2,3),(4,5) gives `result`=26.
